// File: rtl/ic_pkg.sv
// Shared interconnect definitions: AXI field widths, slave-index width helper
// and the AW payload record carried between the master port and the slave arbiters.
package ic_pkg;

   localparam int AXI_ADDR_W = 32;
   localparam int AXI_ID_W   = 5;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_LEN_W  = 3;
   localparam int AXI_SIZE_W = 3;

   // Width of a slave index; never below one bit so a single-slave build still has a port.
   function automatic int slv_id_w(input int slv_amt);
      return (slv_amt > 1) ? $clog2(slv_amt) : 1;
   endfunction

   typedef struct packed {
      logic [AXI_ID_W-1:0]    id;
      logic [AXI_ADDR_W-1:0]  addr;
      logic [AXI_BURST_W-1:0] burst;
      logic [AXI_LEN_W-1:0]   len;
      logic [AXI_SIZE_W-1:0]  size;
   } aw_info_t;

   localparam int AW_INFO_W = $bits(aw_info_t);

endpackage

// File: rtl/dsp_aw_slice.sv
// One-entry register slice for the AW channel. Holds one payload plus the index of
// the slave it is routed to, and presents it as a one-hot valid to that slave.
module dsp_aw_slice
   import ic_pkg::*;
#(
   parameter int PAYLOAD_W = AW_INFO_W,
   parameter int SLV_AMT   = 2,
   parameter int SLV_ID_W  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [PAYLOAD_W-1:0] load_payload,
   input  logic [SLV_ID_W-1:0]  load_id,
   input  logic [SLV_AMT-1:0]   out_ready,
   output logic [SLV_AMT-1:0]   out_valid,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic                 room
);

   logic                slot_vld;
   logic [SLV_ID_W-1:0] slot_id;
   logic                slot_hs;

   // Steer the stored entry to exactly one slave; the slot frees on that slave's handshake.
   always_comb begin
      out_valid = '0;
      for (int i = 0; i < SLV_AMT; i++) begin
         out_valid[i] = slot_vld && (slot_id == SLV_ID_W'(i));
      end
      slot_hs = |(out_valid & out_ready);
      room    = ~slot_vld | slot_hs;
   end

   // Load on accept (also when draining in the same cycle), otherwise empty on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld    <= 1'b0;
         slot_id     <= '0;
         out_payload <= '0;
      end else if (load) begin
         slot_vld    <= 1'b1;
         slot_id     <= load_id;
         out_payload <= load_payload;
      end else if (slot_hs) begin
         slot_vld <= 1'b0;
      end
   end

endmodule

// File: rtl/dsp_aw_channel.sv
// Write-address dispatcher for one master port: decodes the target slave from AWADDR,
// forwards AW through a one-entry slice, strobes the W/B order FIFOs on every routed
// accept and limits the number of writes awaiting their B response.
// Build option DSP_AW_DECERR_EN: out-of-range slave indices are accepted and reported on
// dsp_AW_decerr_o/dsp_AW_decerr_id_o instead of being clamped to the last slave.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits for ready, and the payload stays stable while valid is high and ready low.
module dsp_aw_channel
   import ic_pkg::*;
#(
   parameter int SLV_AMT           = 2,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int ADDR_WIDTH        = AXI_ADDR_W,
   parameter int TRANS_MST_ID_W    = AXI_ID_W,
   parameter int TRANS_BURST_W     = AXI_BURST_W,
   parameter int TRANS_DATA_LEN_W  = AXI_LEN_W,
   parameter int TRANS_DATA_SIZE_W = AXI_SIZE_W,
   parameter int SLV_ID_W          = slv_id_w(SLV_AMT),
   parameter int SLV_ID_MSB_IDX    = 30,
   parameter int SLV_ID_LSB_IDX    = 30
) (
   input  logic                         ACLK_i,
   input  logic                         ARESET_i,
   input  logic [TRANS_MST_ID_W-1:0]    m_AWID_i,
   input  logic [ADDR_WIDTH-1:0]        m_AWADDR_i,
   input  logic [TRANS_BURST_W-1:0]     m_AWBURST_i,
   input  logic [TRANS_DATA_LEN_W-1:0]  m_AWLEN_i,
   input  logic [TRANS_DATA_SIZE_W-1:0] m_AWSIZE_i,
   input  logic                         m_AWVALID_i,
   output logic                         m_AWREADY_o,
   output logic [TRANS_MST_ID_W-1:0]    sa_AWID_o,
   output logic [ADDR_WIDTH-1:0]        sa_AWADDR_o,
   output logic [TRANS_BURST_W-1:0]     sa_AWBURST_o,
   output logic [TRANS_DATA_LEN_W-1:0]  sa_AWLEN_o,
   output logic [TRANS_DATA_SIZE_W-1:0] sa_AWSIZE_o,
   output logic [SLV_AMT-1:0]           sa_AWVALID_o,
   input  logic [SLV_AMT-1:0]           sa_AWREADY_i,
   output logic [SLV_ID_W-1:0]          dsp_AW_slv_id_o,
   output logic [TRANS_DATA_LEN_W-1:0]  dsp_AW_len_o,
   output logic                         dsp_AW_shift_en_o,
   input  logic                         dsp_B_done_i
`ifdef DSP_AW_DECERR_EN
   ,
   output logic                         dsp_AW_decerr_o,
   output logic [TRANS_MST_ID_W-1:0]    dsp_AW_decerr_id_o
`endif
);

   localparam int FLD_W     = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;
   localparam int CNT_W     = $clog2(OUTSTANDING_AMT + 1);
   localparam int PAYLOAD_W = TRANS_MST_ID_W + ADDR_WIDTH + TRANS_BURST_W
                              + TRANS_DATA_LEN_W + TRANS_DATA_SIZE_W;

   logic [FLD_W-1:0]     dec_fld;
   logic [SLV_ID_W-1:0]  dec_id;
   logic [SLV_ID_W-1:0]  route_id;
   logic                 in_range;
   logic                 room;
   logic                 accept;
   logic                 push;
   logic [CNT_W-1:0]     cnt;
   logic [PAYLOAD_W-1:0] slot_payload;

   // Decode the slave index and decide where (and whether) an accepted AW is routed.
   always_comb begin
      dec_fld  = m_AWADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
      dec_id   = SLV_ID_W'(dec_fld);
      in_range = ({1'b0, dec_id} < (SLV_ID_W + 1)'(SLV_AMT));
`ifdef DSP_AW_DECERR_EN
      route_id = dec_id;
`else
      route_id = in_range ? dec_id : SLV_ID_W'(SLV_AMT - 1);
`endif
      m_AWREADY_o = room & (cnt < CNT_W'(OUTSTANDING_AMT)) & ~ARESET_i;
      accept      = m_AWVALID_i & m_AWREADY_o;
`ifdef DSP_AW_DECERR_EN
      push = accept & in_range;
`else
      push = accept;
`endif
      dsp_AW_shift_en_o = push;
      dsp_AW_slv_id_o   = route_id;
      dsp_AW_len_o      = m_AWLEN_i;
   end

   dsp_aw_slice #(
      .PAYLOAD_W (PAYLOAD_W),
      .SLV_AMT   (SLV_AMT),
      .SLV_ID_W  (SLV_ID_W)
   ) u_slice (
      .clk          (ACLK_i),
      .rst          (ARESET_i),
      .load         (push),
      .load_payload ({m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i}),
      .load_id      (route_id),
      .out_ready    (sa_AWREADY_i),
      .out_valid    (sa_AWVALID_o),
      .out_payload  (slot_payload),
      .room         (room)
   );

   assign {sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o} = slot_payload;

   // Count writes pushed to the order FIFOs and not yet answered on B.
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         cnt <= '0;
      end else begin
         case ({push, dsp_B_done_i})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef DSP_AW_DECERR_EN
   // Report an unroutable AW one cycle after it was accepted, tagged with its master ID.
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         dsp_AW_decerr_o    <= 1'b0;
         dsp_AW_decerr_id_o <= '0;
      end else begin
         dsp_AW_decerr_o <= accept & ~in_range;
         if (accept & ~in_range) dsp_AW_decerr_id_o <= m_AWID_i;
      end
   end
`endif

   a_b_done_needs_outstanding : assert property (
      @(posedge ACLK_i) disable iff (ARESET_i) !(dsp_B_done_i && cnt == '0));

endmodule
